// File: rtl/pixel_step_sequencer_if.sv
// Pixel address stream: one linear pixel index per transfer, valid/ready handshake.
// Address and valid stay stable while valid is high and ready is low.
interface pixel_step_sequencer_if #(
    parameter int AW = 16
) ();
    logic          pix_valid;
    logic          pix_ready;
    logic [AW-1:0] pix_addr;

    modport master (
        output pix_valid,
        output pix_addr,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        output pix_ready
    );
endinterface

// File: rtl/pixel_step_sequencer.sv
// Steps a pixel address through an H_PIX x V_PIX frame, one address per slow_clk rise; tick -> pix_valid one edge later.
// Back-pressure stalls the address in place; ticks arriving while an address is pending are dropped and flagged sticky in overrun.
module pixel_step_sequencer #(
    parameter int H_PIX = 8,
    parameter int V_PIX = 6,
    parameter int AW    = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          slow_clk,
    input  logic                          start,
    pixel_step_sequencer_if.master        pix,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun
);

    generate
        if ((longint'(H_PIX) * longint'(V_PIX)) > (longint'(1) << AW)) begin : g_size_check
            $error("pixel_step_sequencer: H_PIX*V_PIX does not fit in AW address bits");
        end
    endgenerate

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          s1;
    logic          s2;
    logic          s3;
    logic          tick;
    logic          xfer;
    logic          last_pix;

    logic          pix_valid_q;
    logic          pix_valid_d;
    logic [AW-1:0] pix_addr_q;
    logic [AW-1:0] pix_addr_d;
    logic          frame_done_q;
    logic          frame_done_d;
    logic          overrun_q;
    logic          overrun_d;

    // slow_clk is asynchronous: two flops to resolve metastability, a third for edge detection
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick     = s2 & ~s3;
    assign xfer     = pix_valid_q & pix.pix_ready;
    assign last_pix = (pix_addr_q == LAST_ADDR);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    state_d = last_pix ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values for the registered outputs; ticks seen in IDLE fall through untouched
    always_comb begin
        pix_valid_d  = pix_valid_q;
        pix_addr_d   = pix_addr_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pix_addr_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    pix_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    pix_valid_d = 1'b0;
                    if (last_pix) begin
                        pix_addr_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_addr_d = pix_addr_q + AW'(1);
                    end
                end
                if (tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                pix_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pix_valid_q  <= 1'b0;
            pix_addr_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            pix_valid_q  <= pix_valid_d;
            pix_addr_q   <= pix_addr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_addr  = pix_addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;

    a_addr_in_frame: assert property (@(posedge clk_in) pix_addr_q <= LAST_ADDR);
    a_done_in_idle:  assert property (@(posedge clk_in) frame_done_q |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_pixel_step_sequencer.sv
// Directed bench for pixel_step_sequencer on a 2x2 frame with hand-computed expectations.
module tb_pixel_step_sequencer;
    localparam int H  = 2;
    localparam int V  = 2;
    localparam int AW = 16;

    logic clk_in;
    logic rst_n;
    logic slow_clk;
    logic start;
    logic busy;
    logic frame_done;
    logic overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    logic [AW-1:0] acc_q[$];

    pixel_step_sequencer_if #(.AW(AW)) pix_if ();

    pixel_step_sequencer #(.H_PIX(H), .V_PIX(V), .AW(AW)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .start      (start),
        .pix        (pix_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rst_n && pix_if.pix_valid && pix_if.pix_ready) acc_q.push_back(pix_if.pix_addr);
        if (frame_done) fd_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; slow_clk = 1'b0; pix_if.pix_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        acc_q.delete();
        fd_cnt = 0;
    endtask

    task automatic slow_period(input int hi, input int lo);
        slow_clk = 1'b1; step(hi);
        slow_clk = 1'b0; step(lo);
    endtask

    task automatic begin_frame();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; slow_clk = 1'b0; pix_if.pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slow_clk = ~slow_clk;
            step(1);
            n_checks++; if (dut.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick[%0d]: got %b want 0", i, dut.tick); end
        end
        n_checks++; if (pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pix_if.pix_valid); end
        n_checks++; if (pix_if.pix_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", pix_if.pix_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        slow_clk = 1'b0; rst_n = 1'b1;
        step(4);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        acc_q.delete(); fd_cnt = 0;
        pix_if.pix_ready = 1'b1;
        begin_frame();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", busy); end
        n_checks++; if (pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL frame_valid_pre: got %b want 0", pix_if.pix_valid); end
        for (int i = 0; i < 3; i++) begin
            slow_clk = 1'b1; step(3);
            n_checks++; if (pix_if.pix_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid[%0d]: got %b want 1", i, pix_if.pix_valid); end
            n_checks++; if (pix_if.pix_addr !== AW'(i)) begin n_fail++; $display("FAIL frame_addr[%0d]: got %0d want %0d", i, pix_if.pix_addr, i); end
            step(17); slow_clk = 1'b0; step(20);
        end
        slow_clk = 1'b1; step(3);
        n_checks++; if (pix_if.pix_addr !== 16'd3) begin n_fail++; $display("FAIL frame_last_addr: got %0d want 3", pix_if.pix_addr); end
        step(1);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_done_busy: got %b want 0", busy); end
        n_checks++; if (pix_if.pix_addr !== 16'd0) begin n_fail++; $display("FAIL frame_wrap_addr: got %0d want 0", pix_if.pix_addr); end
        step(1);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
        slow_clk = 1'b0; step(20);
        n_checks++; if (acc_q.size() !== 4) begin n_fail++; $display("FAIL frame_count: got %0d want 4", acc_q.size()); end
        for (int j = 0; j < acc_q.size(); j++) begin
            n_checks++; if (acc_q[j] !== AW'(j)) begin n_fail++; $display("FAIL frame_seq[%0d]: got %0d want %0d", j, acc_q[j], j); end
        end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL frame_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_sync_latency();
        apply_reset();
        pix_if.pix_ready = 1'b1;
        begin_frame();
        acc_q.delete();
        slow_clk = 1'b1; step(1);
        n_checks++; if (dut.tick !== 1'b0 || pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e1: tick %b valid %b want 0 0", dut.tick, pix_if.pix_valid); end
        step(1);
        n_checks++; if (dut.tick !== 1'b1 || pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e2: tick %b valid %b want 1 0", dut.tick, pix_if.pix_valid); end
        step(1);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || dut.tick !== 1'b0) begin n_fail++; $display("FAIL lat_e3: valid %b tick %b want 1 0", pix_if.pix_valid, dut.tick); end
        step(27);
        n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL lat_one_pixel_high: got %0d want 1", acc_q.size()); end
        slow_clk = 1'b0; step(20);
        n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL lat_fall_ignored: got %0d want 1", acc_q.size()); end
        n_checks++; if (pix_if.pix_addr !== 16'd1) begin n_fail++; $display("FAIL lat_next_addr: got %0d want 1", pix_if.pix_addr); end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        pix_if.pix_ready = 1'b1;
        begin_frame();
        slow_period(20, 20);
        pix_if.pix_ready = 1'b0;
        slow_clk = 1'b1; step(3);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd1) begin n_fail++; $display("FAIL bp_issue: valid %b addr %0d want 1 1", pix_if.pix_valid, pix_if.pix_addr); end
        step(17); slow_clk = 1'b0; step(20);
        slow_clk = 1'b1; step(2);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_early: got %b want 0", overrun); end
        step(1);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b want 1", overrun); end
        step(17); slow_clk = 1'b0; step(20);
        slow_period(20, 20);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd1) begin n_fail++; $display("FAIL bp_hold: valid %b addr %0d want 1 1", pix_if.pix_valid, pix_if.pix_addr); end
        pix_if.pix_ready = 1'b1; step(1);
        n_checks++; if (pix_if.pix_valid !== 1'b0 || pix_if.pix_addr !== 16'd2) begin n_fail++; $display("FAIL bp_release: valid %b addr %0d want 0 2", pix_if.pix_valid, pix_if.pix_addr); end
        slow_clk = 1'b1; step(3);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd2) begin n_fail++; $display("FAIL bp_next: valid %b addr %0d want 1 2", pix_if.pix_valid, pix_if.pix_addr); end
        step(17); slow_clk = 1'b0; step(20);
        n_checks++; if (acc_q.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", acc_q.size()); end
    endtask

    task automatic test_start_busy();
        apply_reset();
        begin_frame();
        slow_clk = 1'b1; step(3);
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd0) begin n_fail++; $display("FAIL sb_ignored: busy %b valid %b addr %0d want 1 1 0", busy, pix_if.pix_valid, pix_if.pix_addr); end
        step(16); slow_clk = 1'b0; step(20);
        slow_period(20, 20);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL sb_overrun: got %b want 1", overrun); end
        pix_if.pix_ready = 1'b1; step(1);
        slow_period(20, 20);
        slow_period(20, 20);
        slow_clk = 1'b1; step(4);
        n_checks++; if (frame_done !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL sb_done_sticky: done %b overrun %b want 1 1", frame_done, overrun); end
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || overrun !== 1'b0 || pix_if.pix_addr !== 16'd0) begin n_fail++; $display("FAIL sb_restart: busy %b overrun %b addr %0d want 1 0 0", busy, overrun, pix_if.pix_addr); end
        slow_clk = 1'b0; step(20);
    endtask

    task automatic test_start_tick_same_cycle();
        apply_reset();
        slow_clk = 1'b1; step(2);
        n_checks++; if (dut.tick !== 1'b1) begin n_fail++; $display("FAIL st_tick: got %b want 1", dut.tick); end
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL st_wait: busy %b valid %b want 1 0", busy, pix_if.pix_valid); end
        step(10);
        n_checks++; if (pix_if.pix_valid !== 1'b0) begin n_fail++; $display("FAIL st_tick_unused: got %b want 0", pix_if.pix_valid); end
        slow_clk = 1'b0; step(10);
        slow_clk = 1'b1; step(3);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd0) begin n_fail++; $display("FAIL st_next_tick: valid %b addr %0d want 1 0", pix_if.pix_valid, pix_if.pix_addr); end
        slow_clk = 1'b0; step(5);
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        pix_if.pix_ready = 1'b1;
        begin_frame();
        slow_period(20, 20);
        slow_period(20, 20);
        slow_clk = 1'b1; step(3);
        n_checks++; if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== 16'd2) begin n_fail++; $display("FAIL mid_pre: valid %b addr %0d want 1 2", pix_if.pix_valid, pix_if.pix_addr); end
        rst_n = 1'b0; step(1);
        n_checks++; if (busy !== 1'b0 || pix_if.pix_valid !== 1'b0 || pix_if.pix_addr !== 16'd0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset: busy %b valid %b addr %0d done %b want 0 0 0 0", busy, pix_if.pix_valid, pix_if.pix_addr, frame_done); end
        rst_n = 1'b1; step(5);
        n_checks++; if (fd_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: done_count %0d busy %b want 0 0", fd_cnt, busy); end
        slow_clk = 1'b0; step(5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_frame();
        test_sync_latency();
        test_back_pressure();
        test_start_busy();
        test_start_tick_same_cycle();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
